// File: rtl/gpu_pkg.sv
// Shared GPU front-end definitions: datapath widths and the fetch-stage state encoding.
package gpu_pkg;

    localparam int PC_WIDTH      = 8;
    localparam int INSTR_WIDTH   = 32;
    localparam int NUM_WARPS     = 4;
    localparam int WARP_ID_WIDTH = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Scheduler, instruction-memory, flush and decoder signals of the fetch stage.
// The master side is the environment; the slave side is the fetch stage.
interface instr_fetch_if;
    import gpu_pkg::*;

    logic                     sched_valid;
    logic                     sched_ready;
    logic [PC_WIDTH-1:0]      sched_pc;
    logic [WARP_ID_WIDTH-1:0] sched_warp;
    logic [NUM_WARPS-1:0]     warp_busy;

    logic                     imem_req_valid;
    logic                     imem_req_ready;
    logic [PC_WIDTH-1:0]      imem_req_addr;
    logic                     imem_rsp_valid;
    logic [INSTR_WIDTH-1:0]   imem_rsp_data;

    logic                     flush_valid;
    logic [WARP_ID_WIDTH-1:0] flush_warp;

    logic                     dec_valid;
    logic                     dec_ready;
    logic [INSTR_WIDTH-1:0]   dec_instr;
    logic [PC_WIDTH-1:0]      dec_pc;
    logic [WARP_ID_WIDTH-1:0] dec_warp;

    modport master (
        output sched_valid, sched_pc, sched_warp,
        input  sched_ready, warp_busy,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output flush_valid, flush_warp,
        input  dec_valid, dec_instr, dec_pc, dec_warp,
        output dec_ready
    );

    modport slave (
        input  sched_valid, sched_pc, sched_warp,
        output sched_ready, warp_busy,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  flush_valid, flush_warp,
        output dec_valid, dec_instr, dec_pc, dec_warp,
        input  dec_ready
    );

endinterface

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch stage between the warp scheduler and the decoder,
// with per-warp busy reporting and per-warp flush for branch redirects.
module instr_fetch
    import gpu_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.slave  bus
);

    fetch_state_e             state_q, state_d;
    logic [PC_WIDTH-1:0]      pc_q, pc_d;
    logic [WARP_ID_WIDTH-1:0] warp_q, warp_d;
    logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
    logic                     drop_q, drop_d;
    logic                     flush_hit;

    assign flush_hit = bus.flush_valid && (bus.flush_warp == warp_q);

    always_comb begin
        state_d            = state_q;
        pc_d               = pc_q;
        warp_d             = warp_q;
        instr_d            = instr_q;
        drop_d             = drop_q;
        bus.sched_ready    = 1'b0;
        bus.imem_req_valid = 1'b0;
        bus.dec_valid      = 1'b0;

        case (state_q)
            IDLE: begin
                bus.sched_ready = 1'b1;
                if (bus.sched_valid) begin
                    pc_d    = bus.sched_pc;
                    warp_d  = bus.sched_warp;
                    state_d = REQ;
                end
            end
            REQ: begin
                bus.imem_req_valid = 1'b1;
                if (bus.imem_req_ready) begin
                    // A read already handed to memory cannot be recalled; its data is dropped later.
                    state_d = WAIT;
                    drop_d  = flush_hit;
                end else if (flush_hit) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (bus.imem_rsp_valid) begin
                    drop_d = 1'b0;
                    if (drop_q || flush_hit) begin
                        state_d = IDLE;
                    end else begin
                        instr_d = bus.imem_rsp_data;
                        state_d = HOLD;
                    end
                end else if (flush_hit) begin
                    drop_d = 1'b1;
                end
            end
            HOLD: begin
                // dec_valid is masked by a matching flush so the decoder never takes a killed word.
                if (flush_hit) begin
                    state_d = IDLE;
                end else begin
                    bus.dec_valid = 1'b1;
                    if (bus.dec_ready) begin
                        bus.sched_ready = 1'b1;
                        if (bus.sched_valid) begin
                            pc_d    = bus.sched_pc;
                            warp_d  = bus.sched_warp;
                            state_d = REQ;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.warp_busy = '0;
        if (state_q != IDLE) begin
            bus.warp_busy[warp_q] = 1'b1;
        end
    end

    assign bus.imem_req_addr = pc_q;
    assign bus.dec_instr     = instr_q;
    assign bus.dec_pc        = pc_q;
    assign bus.dec_warp      = warp_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            warp_q  <= '0;
            instr_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            warp_q  <= warp_d;
            instr_q <= instr_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by randomized traffic checked
// against a transaction-level scoreboard of the single outstanding fetch.
module tb_instr_fetch;
    import gpu_pkg::*;

    logic clk = 1'b0;
    logic reset;

    instr_fetch_if bus();

    instr_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory contents used during random traffic: a fixed function of the address.
    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return {a, ~a, a ^ 8'h5A, 8'hC3};
    endfunction

    task automatic idle_inputs();
        bus.sched_valid    = 1'b0;
        bus.sched_pc       = '0;
        bus.sched_warp     = '0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.flush_valid    = 1'b0;
        bus.flush_warp     = '0;
        bus.dec_ready      = 1'b0;
    endtask

    task automatic cyc();
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_sched_ready"}, bus.sched_ready, 1);
        chk({tag, "_imem_req_valid"}, bus.imem_req_valid, 0);
        chk({tag, "_imem_req_addr"}, bus.imem_req_addr, 0);
        chk({tag, "_warp_busy"}, bus.warp_busy, 0);
        chk({tag, "_dec_valid"}, bus.dec_valid, 0);
        chk({tag, "_dec_instr"}, bus.dec_instr, 0);
        chk({tag, "_dec_pc"}, bus.dec_pc, 0);
        chk({tag, "_dec_warp"}, bus.dec_warp, 0);
    endtask

    // Scoreboard state for the one fetch the stage may own.
    logic       t_valid, t_done, t_killed, t_issued;
    logic [7:0] t_pc;
    logic [1:0] t_warp;
    int         n_acc, n_kill, n_del;
    logic       mem_pend;
    int         mem_cnt;
    logic [31:0] mem_data;

    initial begin
        logic live, hit, imem_hs, dec_hs, sched_hs, rsp_fire, drain;

        reset = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);

        // Basic fetch
        cyc(); reset = 1'b0;
        bus.sched_valid = 1'b1; bus.sched_pc = 8'h10; bus.sched_warp = 2'd2;
        #1;
        check_reset_values("rst");
        cyc(); bus.imem_req_ready = 1'b1; #1;
        chk("basic_req_valid", bus.imem_req_valid, 1);
        chk("basic_req_addr", bus.imem_req_addr, 32'h10);
        chk("basic_busy_req", bus.warp_busy, 4'b0100);
        chk("basic_sched_ready_req", bus.sched_ready, 0);
        cyc(); bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hDEADBEEF; #1;
        chk("basic_busy_wait", bus.warp_busy, 4'b0100);
        chk("basic_no_dec_wait", bus.dec_valid, 0);
        cyc(); #1;
        chk("basic_dec_valid", bus.dec_valid, 1);
        chk("basic_dec_instr", bus.dec_instr, 32'hDEADBEEF);
        chk("basic_dec_pc", bus.dec_pc, 32'h10);
        chk("basic_dec_warp", bus.dec_warp, 2);
        chk("basic_busy_hold", bus.warp_busy, 4'b0100);
        cyc(); bus.dec_ready = 1'b1; #1;
        chk("basic_sched_ready_hs", bus.sched_ready, 1);
        cyc(); #1;
        chk("basic_idle_dec", bus.dec_valid, 0);
        chk("basic_idle_busy", bus.warp_busy, 0);

        // Backpressure on memory then decoder
        cyc(); bus.sched_valid = 1'b1; bus.sched_pc = 8'h44; bus.sched_warp = 2'd0; #1;
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            chk("bp_req_valid", bus.imem_req_valid, 1);
            chk("bp_req_addr", bus.imem_req_addr, 32'h44);
            chk("bp_sched_ready", bus.sched_ready, 0);
        end
        cyc(); bus.imem_req_ready = 1'b1; #1;
        chk("bp_req_addr_hs", bus.imem_req_addr, 32'h44);
        cyc(); bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hCAFEF00D; #1;
        for (int i = 0; i < 4; i++) begin
            cyc(); #1;
            chk("bp_dec_valid", bus.dec_valid, 1);
            chk("bp_dec_instr", bus.dec_instr, 32'hCAFEF00D);
            chk("bp_dec_pc", bus.dec_pc, 32'h44);
            chk("bp_dec_warp", bus.dec_warp, 0);
            chk("bp_sched_ready_hold", bus.sched_ready, 0);
        end

        // Back-to-back accept from HOLD
        cyc(); bus.dec_ready = 1'b1;
        bus.sched_valid = 1'b1; bus.sched_pc = 8'h20; bus.sched_warp = 2'd1; #1;
        chk("b2b_sched_ready", bus.sched_ready, 1);
        cyc(); #1;
        chk("b2b_req_valid", bus.imem_req_valid, 1);
        chk("b2b_req_addr", bus.imem_req_addr, 32'h20);
        chk("b2b_busy", bus.warp_busy, 4'b0010);
        cyc(); bus.imem_req_ready = 1'b1; #1;
        cyc(); bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h55AA33CC; #1;

        // Flush of another warp, then flush of the held warp
        cyc(); bus.flush_valid = 1'b1; bus.flush_warp = 2'd0; #1;
        chk("fmis_dec_valid", bus.dec_valid, 1);
        chk("fmis_dec_instr", bus.dec_instr, 32'h55AA33CC);
        cyc(); #1;
        chk("fmis_dec_valid_after", bus.dec_valid, 1);
        chk("fmis_busy", bus.warp_busy, 4'b0010);
        cyc(); bus.flush_valid = 1'b1; bus.flush_warp = 2'd1; bus.dec_ready = 1'b1; #1;
        chk("fhold_sched_ready", bus.sched_ready, 0);
        chk("fhold_no_handshake", bus.dec_valid, 0);
        cyc(); #1;
        chk("fhold_dec_valid", bus.dec_valid, 0);
        chk("fhold_busy", bus.warp_busy, 0);
        chk("fhold_sched_ready_idle", bus.sched_ready, 1);

        // Flush while waiting on memory
        cyc(); bus.sched_valid = 1'b1; bus.sched_pc = 8'h30; bus.sched_warp = 2'd3; #1;
        cyc(); bus.imem_req_ready = 1'b1; #1;
        chk("fwait_busy_req", bus.warp_busy, 4'b1000);
        cyc(); bus.flush_valid = 1'b1; bus.flush_warp = 2'd3; #1;
        chk("fwait_busy_flush", bus.warp_busy, 4'b1000);
        cyc(); #1;
        chk("fwait_busy_drop", bus.warp_busy, 4'b1000);
        chk("fwait_sched_ready", bus.sched_ready, 0);
        cyc(); bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h12345678; #1;
        chk("fwait_no_dec_rsp", bus.dec_valid, 0);
        cyc(); #1;
        chk("fwait_dec_valid", bus.dec_valid, 0);
        chk("fwait_busy_idle", bus.warp_busy, 0);
        chk("fwait_sched_ready_idle", bus.sched_ready, 1);
        cyc(); #1;
        chk("fwait_dec_valid_later", bus.dec_valid, 0);

        // Reset while waiting on memory, late response ignored
        cyc(); bus.sched_valid = 1'b1; bus.sched_pc = 8'h50; bus.sched_warp = 2'd1; #1;
        cyc(); bus.imem_req_ready = 1'b1; #1;
        cyc(); reset = 1'b1; #1;
        cyc(); reset = 1'b0; bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hFFFFFFFF; #1;
        check_reset_values("rstwait");
        cyc(); #1;
        chk("rstwait_dec_after", bus.dec_valid, 0);
        chk("rstwait_busy_after", bus.warp_busy, 0);
        chk("rstwait_instr_after", bus.dec_instr, 0);

        // Randomized traffic against the scoreboard
        t_valid = 0; t_done = 0; t_killed = 0; t_issued = 0; t_pc = '0; t_warp = '0;
        n_acc = 0; n_kill = 0; n_del = 0;
        mem_pend = 0; mem_cnt = 0; mem_data = '0;
        for (int c = 0; c < 3020; c++) begin
            cyc();
            drain = (c >= 3000);
            bus.imem_req_ready = drain ? 1'b1 : ($urandom_range(0, 4) < 3);
            rsp_fire = mem_pend && (mem_cnt == 0);
            if (rsp_fire) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = mem_data;
            end else if (mem_pend) begin
                mem_cnt--;
            end else if (!bus.imem_req_ready && ($urandom_range(0, 7) == 0)) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = 32'hBAD00000 | $urandom_range(0, 255);
            end
            bus.sched_valid = !drain && ($urandom_range(0, 1) == 1);
            bus.sched_pc    = 8'($urandom_range(0, 255));
            bus.sched_warp  = 2'($urandom_range(0, 3));
            bus.dec_ready   = drain ? 1'b1 : ($urandom_range(0, 4) < 3);
            bus.flush_valid = !drain && ($urandom_range(0, 9) == 0);
            bus.flush_warp  = 2'($urandom_range(0, 3));
            #1;

            live     = t_valid && !t_done && !t_killed;
            hit      = live && bus.flush_valid && (bus.flush_warp == t_warp);
            imem_hs  = bus.imem_req_valid && bus.imem_req_ready;
            dec_hs   = bus.dec_valid && bus.dec_ready;
            sched_hs = bus.sched_valid && bus.sched_ready;

            if (live)
                chk("rnd_busy_live", bus.warp_busy, 32'd1 << t_warp);
            else if (!t_valid || t_done)
                chk("rnd_busy_idle", bus.warp_busy, 0);
            else if (bus.warp_busy != 0)
                chk("rnd_busy_killed", bus.warp_busy, 32'd1 << t_warp);

            if (!live || hit)
                chk("rnd_dec_valid_dead", bus.dec_valid, 0);

            if (rsp_fire) mem_pend = 0;
            if (imem_hs) begin
                chk("rnd_imem_live", live, 1);
                chk("rnd_imem_once", t_issued, 0);
                chk("rnd_imem_addr", bus.imem_req_addr, t_pc);
                t_issued = 1;
                mem_pend = 1;
                mem_cnt  = $urandom_range(0, 2);
                mem_data = mem_word(bus.imem_req_addr);
            end

            if (dec_hs) begin
                chk("rnd_dec_live", live, 1);
                chk("rnd_dec_pc", bus.dec_pc, t_pc);
                chk("rnd_dec_warp", bus.dec_warp, t_warp);
                chk("rnd_dec_instr", bus.dec_instr, mem_word(t_pc));
                t_done = 1;
                n_del++;
            end

            if (!t_valid || t_done)
                chk("rnd_sched_ready_free", bus.sched_ready, 1);
            else if (!t_killed)
                chk("rnd_sched_ready_busy", bus.sched_ready, 0);

            if (hit) begin
                t_killed = 1;
                n_kill++;
            end

            if (sched_hs) begin
                chk("rnd_accept_free", t_valid ? (t_done || t_killed) : 1'b1, 1);
                t_valid  = 1;
                t_done   = 0;
                t_killed = 0;
                t_issued = 0;
                t_pc     = bus.sched_pc;
                t_warp   = bus.sched_warp;
                n_acc++;
            end
        end

        chk("rnd_final_done", t_valid ? (t_done || t_killed) : 1'b1, 1);
        chk("rnd_deliveries", n_del, n_acc - n_kill);
        chk("rnd_progress", n_del > 50, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage directly downstream of the warp scheduler. It accepts one (pc, warp) fetch request at a time from the scheduler, issues it to instruction memory, captures the returned instruction word, and presents it with its pc and warp id to the decoder through a valid/ready handshake. It also reports a per-warp busy vector so the scheduler never selects a warp that still has a fetch in flight, and it supports per-warp flush for branch redirects.

## Interface
- PC_WIDTH, 8, instruction address width
- INSTR_WIDTH, 32, instruction word width
- NUM_WARPS, 4, number of warps
- WARP_ID_WIDTH, 2, warp id width (log2 NUM_WARPS)
- clk  in  1  single clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- sched_valid  in  1  scheduler presents a fetch request
- sched_ready  out  1  fetch stage accepts the request this cycle
- sched_pc  in  PC_WIDTH  pc to fetch
- sched_warp  in  WARP_ID_WIDTH  warp owning sched_pc
- warp_busy  out  NUM_WARPS  bit w set while warp w has a fetch latched in this stage
- imem_req_valid  out  1  memory read request
- imem_req_ready  in  1  memory accepts the request
- imem_req_addr  out  PC_WIDTH  read address
- imem_rsp_valid  in  1  read data valid; single-cycle pulse
- imem_rsp_data  in  INSTR_WIDTH  instruction word
- flush_valid  in  1  redirect: discard any fetch belonging to flush_warp
- flush_warp  in  WARP_ID_WIDTH  warp being flushed
- dec_valid  out  1  instruction available to decoder
- dec_ready  in  1  decoder accepts it
- dec_instr  out  INSTR_WIDTH  fetched word
- dec_pc  out  PC_WIDTH  its pc
- dec_warp  out  WARP_ID_WIDTH  its warp

## Operation
- The FSM has four states: IDLE, REQ, WAIT, HOLD. A registered pc, warp, instruction word and a drop flag are held alongside it.
- IDLE: sched_ready=1. When sched_valid is high, latch sched_pc and sched_warp, then go to REQ.
- REQ: imem_req_valid=1 and imem_req_addr = latched pc. When imem_req_ready is high, go to WAIT.
- WAIT: when imem_rsp_valid is high, latch imem_rsp_data. Go to HOLD, or go to IDLE if drop is set; drop is cleared on that transition.
- HOLD: dec_valid=1, and the dec_* outputs come straight from registers. When dec_ready is high, sched_ready=1 in the same cycle. If sched_valid is also high, latch the new request and go to REQ; otherwise go to IDLE.
- warp_busy is one-hot on the latched warp in REQ, WAIT and HOLD, and all zero in IDLE.
- Flush applies when flush_valid is high and flush_warp equals the latched warp. It has priority over every other transition.
  - In REQ with no imem handshake that cycle: go to IDLE and issue no request.
  - In REQ with an imem handshake the same cycle: go to WAIT and set drop.
  - In WAIT: set drop and stay until the response arrives. A response arriving in the same cycle is discarded, and the FSM goes to IDLE.
  - In HOLD: go to IDLE and deassert dec_valid, even if dec_ready was high that cycle. sched_ready is 0 that cycle.
- A flush never affects a request being accepted from the scheduler in the same cycle.
- imem_rsp_valid outside WAIT is ignored.
- Reset at any point: state goes to IDLE, drop=0, and all data registers are cleared. An in-flight memory response after reset is ignored.

## Timing
- Reset values: state=IDLE, sched_ready=1, imem_req_valid=0, imem_req_addr=0, warp_busy=0, dec_valid=0, dec_instr=0, dec_pc=0, dec_warp=0.
- Best-case latency: request accepted at edge N puts the stage in REQ during N+1. With imem_req_ready=1 it enters WAIT at N+2; a response in that cycle makes dec_valid=1 from N+3.
- Throughput is at most one instruction per 3 cycles, because only one fetch is outstanding at a time.
- sched_ready depends combinationally on state, dec_ready and flush only; it never depends on sched_valid.
- imem_req_valid, once asserted, stays stable with a fixed address until the handshake completes or a flush occurs.
- dec_* outputs stay stable while dec_valid=1 and dec_ready=0.

## Structure
- The shared package gpu_pkg holds PC_WIDTH, INSTR_WIDTH, NUM_WARPS, WARP_ID_WIDTH and the fetch state enum (IDLE, REQ, WAIT, HOLD).
- The block is a single module with no sub-modules.

## Test plan
- Basic fetch: after reset, sched_pc=0x10 and warp 2, imem ready, response 0xDEADBEEF one cycle after the handshake. Expect dec_valid at N+3 with dec_instr=0xDEADBEEF, dec_pc=0x10, dec_warp=2, and warp_busy=4'b0100 throughout.
- Backpressure: imem_req_ready low for 3 cycles, then dec_ready low for 4 cycles. Expect the request address held constant, the dec_* outputs held stable, and sched_ready=0 until the dec handshake.
- Back-to-back: in HOLD with dec_ready=1 and sched_valid=1 (pc 0x20, warp 1). Expect the next cycle to be REQ with imem_req_addr=0x20 and warp_busy=4'b0010.
- Flush in WAIT: warp 3 is in WAIT when flush_warp=3 arrives; response 0x12345678 follows. Expect no dec_valid, a return to IDLE, and warp_busy=0.
- Flush mismatch and HOLD flush: flush_warp=0 while warp 1 is in HOLD has no effect. flush_warp=1 while warp 1 is in HOLD, with dec_ready=1 the same cycle, gives dec_valid=0 the next cycle and no decoder handshake.
- Reset mid-WAIT: assert reset, then deliver imem_rsp_valid after reset. Expect state IDLE, all outputs at their reset values, and the response ignored.
